char_grid_buf: RTL
==================

CHAR_GRID_BUF -- requirements
Module: char_grid_buf

Interface
REQ-001 SHALL have parameter P_NUM_ROWS, default 32, meaning text rows held (power of 2, 4..64).
REQ-002 SHALL have parameter P_NUM_COLS, default 32, meaning text columns held (power of 2, 4..128).
REQ-003 SHALL have parameter P_ATTR_W, default 4, meaning per-cell colour attribute width (1..8).
REQ-004 SHALL have parameter P_TAB_W, default 4, meaning tab stop spacing (power of 2, < P_NUM_COLS).
REQ-005 SHALL have ports:
  clk  in  1  clock; all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  ascii  in  8  stream character
  attr  in  P_ATTR_W  attribute stored with ascii
  ascii_val  in  1  stream valid
  ascii_rdy  out  1  stream ready; transfer when val&rdy
  read_hchar  in  7  read column (8x8 tiles)
  read_vchar  in  6  read display row
  read_hoffset  in  3  pixel column in glyph
  read_voffset  in  3  pixel row in glyph
  read_lit  out  1  pixel lit, 1-cycle latency
  read_attr  out  P_ATTR_W  attribute of read cell, 1-cycle latency
  out_of_bounds  out  1  read coordinate outside grid, 1-cycle latency

Function
REQ-006 SHALL store one 8-bit code plus P_ATTR_W attribute per cell; cleared cell = code 0x00, attr 0.
REQ-007 SHALL decode on transfer: 0x1B ESC clear all; 0x0A LF newline; 0x0D CR column 0; 0x08 BS and 0xFF DEL delete; 0x09 TAB; any other code written at cursor.
REQ-008 Printable write SHALL store {ascii,attr} at cursor, cursor_x+1; at cursor_x=P_NUM_COLS-1 SHALL act as newline after the write.
REQ-009 Delete at cursor_x>0 SHALL decrement cursor_x and clear that cell; at cursor_x=0 SHALL be a no-op (no row wrap).
REQ-010 TAB SHALL advance cursor_x to next multiple of P_TAB_W, writing nothing; crossing last column SHALL act as newline.
REQ-011 Newline SHALL set cursor_x=0, move cursor_y to next physical row (mod P_NUM_ROWS) and start clearing that row.
REQ-012 SHALL track line_cnt (saturating at P_NUM_ROWS-1); once saturated every newline SHALL increment top pointer (mod P_NUM_ROWS), scrolling by one row.
REQ-013 Physical read row SHALL be (read_vchar + top) mod P_NUM_ROWS; read column = read_hchar low bits.
REQ-014 FSM states IDLE, CLR_ROW, CLR_ALL; ascii_rdy=1 only in IDLE.
REQ-015 IDLE->CLR_ROW on newline; CLR_ROW clears one cell per cycle, column 0..P_NUM_COLS-1, returns to IDLE after the last column (P_NUM_COLS cycles).
REQ-016 IDLE->CLR_ALL on ESC; CLR_ALL clears one cell per cycle, row-major, P_NUM_ROWS*P_NUM_COLS cycles, then IDLE; cursor, top, line_cnt zeroed on entering CLR_ALL.
REQ-017 ascii_val while ascii_rdy=0 SHALL be ignored (held by sender, no state change).
REQ-018 Read port SHALL be independent of the FSM; reads of a row mid-clear return whatever the cell holds that cycle.
REQ-019 out_of_bounds SHALL be registered (read_hchar>=P_NUM_COLS | read_vchar>=P_NUM_ROWS); when set, read_lit=0 and read_attr=0.
REQ-020 read_lit SHALL come from the existing 8x8 glyph ROM on the registered code, overridden to 1 for the cursor underline (cursor cell, voffset=7, hoffset!=7) when cursor is visible.

Reset
REQ-021 rst SHALL asynchronously force: FSM IDLE, cursor (0,0), top 0, line_cnt 0, ascii_rdy 1, read_lit 0, read_attr 0, out_of_bounds 1, blink counter 0.
REQ-022 Cell storage SHALL be cleared by entering CLR_ALL on reset release (ascii_rdy 0 for P_NUM_ROWS*P_NUM_COLS cycles), not by asynchronous reset of the array.
REQ-023 Reset asserted mid-clear SHALL abort it; release SHALL restart a full clear.

Configuration
REQ-024 With CHAR_GRID_BUF_CURSOR_BLINK_EN defined SHALL include a free-running 24-bit counter; cursor visible while bit 23 = 0.
REQ-025 Without CHAR_GRID_BUF_CURSOR_BLINK_EN cursor SHALL be always visible and the counter absent.

Verification
REQ-026 Reset, wait for ascii_rdy, send 'A' attr 3 -> read (0,0) code 0x41, read_attr 3 next cycle; cursor at (1,0).
REQ-027 Send 'H','I',DEL -> cell (1,0)=0x00, cursor (1,0); DEL at column 0 -> no change.
REQ-028 Send LF -> ascii_rdy low exactly P_NUM_COLS cycles; row 1 all zero; cursor (0,1).
REQ-029 Send P_NUM_ROWS LFs after 'Z' on row 0 -> top=1 after final LF, 'Z' no longer readable at display row 0.
REQ-030 TAB at cursor_x=1 -> cursor_x=4 (P_TAB_W=4); TAB at cursor_x=P_NUM_COLS-2 -> newline.
REQ-031 read_hchar=P_NUM_COLS -> out_of_bounds=1, read_lit=0 next cycle; ESC -> ascii_rdy low P_NUM_ROWS*P_NUM_COLS cycles, all cells 0.

Source files
------------

// File: rtl/char_grid_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : char_grid_buf_if
// Description : Character stream and pixel read bus for char_grid_buf.
//               master = character source / display scanner,
//               slave  = char_grid_buf.
//   ascii/attr/ascii_val -> stream in, ascii_rdy <- stream ready
//   read_hchar/read_vchar/read_hoffset/read_voffset -> pixel query
//   read_lit/read_attr/out_of_bounds <- pixel result (1-cycle latency)
// Revision    : 1.0  initial release
// ============================================================================
interface char_grid_buf_if #(
  parameter int P_ATTR_W = 4
);
  logic [7:0]          ascii;
  logic [P_ATTR_W-1:0] attr;
  logic                ascii_val;
  logic                ascii_rdy;
  logic [6:0]          read_hchar;
  logic [5:0]          read_vchar;
  logic [2:0]          read_hoffset;
  logic [2:0]          read_voffset;
  logic                read_lit;
  logic [P_ATTR_W-1:0] read_attr;
  logic                out_of_bounds;

  modport master (
    output ascii, attr, ascii_val, read_hchar, read_vchar, read_hoffset, read_voffset,
    input  ascii_rdy, read_lit, read_attr, out_of_bounds
  );

  modport slave (
    input  ascii, attr, ascii_val, read_hchar, read_vchar, read_hoffset, read_voffset,
    output ascii_rdy, read_lit, read_attr, out_of_bounds
  );
endinterface
`default_nettype wire

// File: rtl/char_grid_buf.sv
`default_nettype none
// ============================================================================
// Module      : char_grid_buf
// Description : Scrolling text grid fed by an ASCII stream. Each cell holds
//               an 8-bit code plus an attribute. A pixel read port turns a
//               (column, display row, glyph x, glyph y) query into a lit bit
//               via an 8x8 glyph ROM, with an underline cursor overlay.
// Ports       : clk, rst (async, active-high)
//               bus (char_grid_buf_if.slave): stream in + pixel read port
// Options     : `define CHAR_GRID_BUF_CURSOR_BLINK_EN -> cursor blinks from a
//               free-running 24-bit counter (visible while bit 23 = 0);
//               otherwise the cursor is always visible.
// Revision    : 1.0  initial release
// ============================================================================
module char_grid_buf #(
  parameter int P_NUM_ROWS = 32,
  parameter int P_NUM_COLS = 32,
  parameter int P_ATTR_W   = 4,
  parameter int P_TAB_W    = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  char_grid_buf_if.slave bus
);

  localparam int RW    = $clog2(P_NUM_ROWS);
  localparam int CW    = $clog2(P_NUM_COLS);
  localparam int AW    = RW + CW;
  localparam int TW    = $clog2(P_TAB_W);
  localparam int DW    = 8 + P_ATTR_W;
  localparam int NCELL = P_NUM_ROWS * P_NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_CLR_ALL = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cur_x_q;
  logic [RW-1:0]   cur_y_q;
  logic [RW-1:0]   top_q;
  logic [RW-1:0]   line_cnt_q;
  logic [AW-1:0]   clr_idx_q;
  logic            rdy_q;
  logic            init_q;      // full clear still owed after reset release
  logic            oob_q;
  logic            hit_q;       // registered cursor-underline hit
  logic [2:0]      hoff_q;
  logic [2:0]      voff_q;
  logic [DW-1:0]   cell_q;      // registered cell read (no reset, masked by oob_q)

  logic [DW-1:0]   mem [NCELL];

  // --------------------------------------------------------------------------
  // Cursor visibility
  // --------------------------------------------------------------------------
  logic cursor_vis;
`ifdef CHAR_GRID_BUF_CURSOR_BLINK_EN
  logic [23:0] blink_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + 24'd1;
  end
  assign cursor_vis = ~blink_q[23];
`else
  assign cursor_vis = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Stream decode
  // --------------------------------------------------------------------------
  logic          xfer;
  logic          is_esc, is_lf, is_cr, is_del, is_tab, is_print;
  logic          at_last;
  logic [CW:0]   tab_next;
  logic          nl_evt;

  assign xfer     = (state_q == ST_IDLE) && !init_q && bus.ascii_val;
  assign is_esc   = (bus.ascii == 8'h1B);
  assign is_lf    = (bus.ascii == 8'h0A);
  assign is_cr    = (bus.ascii == 8'h0D);
  assign is_del   = (bus.ascii == 8'h08) || (bus.ascii == 8'hFF);
  assign is_tab   = (bus.ascii == 8'h09);
  assign is_print = !(is_esc || is_lf || is_cr || is_del || is_tab);
  assign at_last  = (cur_x_q == CW'(P_NUM_COLS - 1));
  // Next tab stop, one bit wider so that reaching P_NUM_COLS shows up in the MSB.
  assign tab_next = (({1'b0, cur_x_q} >> TW) + (CW+1)'(1)) << TW;
  assign nl_evt   = xfer && (is_lf || (is_tab && tab_next[CW]) || (is_print && at_last));

  // --------------------------------------------------------------------------
  // Cell write port: one write per cycle, chosen by state
  // --------------------------------------------------------------------------
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (xfer && is_print) begin
          mem_we    = 1'b1;
          mem_waddr = {cur_y_q, cur_x_q};
          mem_wdata = {bus.ascii, bus.attr};
        end else if (xfer && is_del && (cur_x_q != '0)) begin
          mem_we    = 1'b1;
          mem_waddr = {cur_y_q, cur_x_q - CW'(1)};
        end
      end
      ST_CLR_ROW: begin
        mem_we    = 1'b1;
        mem_waddr = {cur_y_q, clr_idx_q[CW-1:0]};
      end
      ST_CLR_ALL: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read path address
  // --------------------------------------------------------------------------
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          rd_oob;
  logic          rd_hit;

  assign rd_row = bus.read_vchar[RW-1:0] + top_q;
  assign rd_col = bus.read_hchar[CW-1:0];
  assign rd_oob = ({1'b0, bus.read_hchar} >= 8'(P_NUM_COLS)) ||
                  ({1'b0, bus.read_vchar} >= 7'(P_NUM_ROWS));
  assign rd_hit = cursor_vis && (rd_row == cur_y_q) && (rd_col == cur_x_q) &&
                  (bus.read_voffset == 3'd7) && (bus.read_hoffset != 3'd7);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    cell_q <= mem[{rd_row, rd_col}];
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered read status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      top_q      <= '0;
      line_cnt_q <= '0;
      clr_idx_q  <= '0;
      rdy_q      <= 1'b1;
      init_q     <= 1'b1;
      oob_q      <= 1'b1;
      hit_q      <= 1'b0;
      hoff_q     <= '0;
      voff_q     <= '0;
    end else begin
      oob_q  <= rd_oob;
      hit_q  <= rd_hit;
      hoff_q <= bus.read_hoffset;
      voff_q <= bus.read_voffset;

      case (state_q)
        ST_IDLE: begin
          // The first cycle after reset release starts the full clear; a
          // character offered in that single cycle is not taken.
          if (init_q || (xfer && is_esc)) begin
            init_q     <= 1'b0;
            state_q    <= ST_CLR_ALL;
            rdy_q      <= 1'b0;
            clr_idx_q  <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            top_q      <= '0;
            line_cnt_q <= '0;
          end else if (nl_evt) begin
            cur_x_q   <= '0;
            cur_y_q   <= cur_y_q + RW'(1);
            if (line_cnt_q == RW'(P_NUM_ROWS - 1)) top_q <= top_q + RW'(1);
            else                                   line_cnt_q <= line_cnt_q + RW'(1);
            clr_idx_q <= '0;
            state_q   <= ST_CLR_ROW;
            rdy_q     <= 1'b0;
          end else if (xfer) begin
            if (is_cr)                             cur_x_q <= '0;
            else if (is_del && (cur_x_q != '0))    cur_x_q <= cur_x_q - CW'(1);
            else if (is_tab)                       cur_x_q <= tab_next[CW-1:0];
            else if (is_print)                     cur_x_q <= cur_x_q + CW'(1);
          end
        end
        ST_CLR_ROW: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q[CW-1:0] == CW'(P_NUM_COLS - 1)) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        ST_CLR_ALL: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NCELL - 1)) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Glyph ROM: 'A' is a real glyph, other printable codes show a box, control
  // codes and space are blank. Bit 7 of a row is the leftmost pixel.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [2:0] row);
    logic [7:0] r;
    r = 8'h00;
    if (code == 8'h41) begin
      case (row)
        3'd0:    r = 8'h18;
        3'd1:    r = 8'h3C;
        3'd2:    r = 8'h66;
        3'd3:    r = 8'h66;
        3'd4:    r = 8'h7E;
        3'd5:    r = 8'h66;
        3'd6:    r = 8'h66;
        default: r = 8'h00;
      endcase
    end else if (code > 8'h20) begin
      case (row)
        3'd1, 3'd6:             r = 8'h7E;
        3'd2, 3'd3, 3'd4, 3'd5: r = 8'h42;
        default:                r = 8'h00;
      endcase
    end
    return r;
  endfunction

  logic [7:0] gl_row;
  assign gl_row = glyph_row(cell_q[DW-1:P_ATTR_W], voff_q);

  assign bus.ascii_rdy     = rdy_q;
  assign bus.out_of_bounds = oob_q;
  assign bus.read_attr     = oob_q ? '0 : cell_q[P_ATTR_W-1:0];
  assign bus.read_lit      = !oob_q && (hit_q || gl_row[3'd7 - hoff_q]);

endmodule
`default_nettype wire
